// File: rtl/count_pkg.sv
// Shared types and constants for the mod-12 counter arbitration controller.
package count_pkg;

    localparam int MOD12 = 12;
    localparam int CNT_W = 4;
    localparam int LEN_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } arb_state_e;

    // A start value is usable only if the counter can actually hold it.
    function automatic logic start_ok(input logic [CNT_W-1:0] start, input int modulus);
        return (int'(start) < modulus);
    endfunction

endpackage

// File: rtl/count_arb_ctrl_if.sv
// Requester-side bundle: request handshake with per-requester fields, and the response strobe.
interface count_arb_ctrl_if;
    import count_pkg::*;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][CNT_W-1:0] req_start;
    logic [1:0]            req_mode;
    logic [1:0][LEN_W-1:0] req_len;
    logic [1:0]            rsp_valid;
    logic [CNT_W-1:0]      rsp_value;
    logic                  rsp_err;

    modport master (
        output req_valid, req_start, req_mode, req_len,
        input  req_ready, rsp_valid, rsp_value, rsp_err
    );

    modport slave (
        input  req_valid, req_start, req_mode, req_len,
        output req_ready, rsp_valid, rsp_value, rsp_err
    );

endinterface

// File: rtl/count_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past whoever was just served.
module count_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant
);

    logic prio_r;

    // Priority pointer, updated on each accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (advance) begin
            prio_r <= ~grant;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Grant selection: pointer breaks ties, a lone requester always wins
    always_comb begin
        grant = 1'b0;
        case (valid)
            2'b11:   grant = prio_r;
            2'b10:   grant = 1'b1;
            2'b01:   grant = 1'b0;
            default: grant = prio_r;
        endcase
    end

endmodule

// File: rtl/count_arb_ctrl.sv
// Shares one mod-12 counter between two requesters: arbitrates, sequences load/count,
// and returns the final counter value with a one-cycle strobe.
module count_arb_ctrl
    import count_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int MOD  = 12
) (
    input  logic              clk,
    input  logic              rst,
    count_arb_ctrl_if.slave   bus,
    output logic              cnt_rst,
    output logic              cnt_load,
    output logic              cnt_mode,
    output logic [CNT_W-1:0]  cnt_data_in,
    input  logic [CNT_W-1:0]  cnt_data_out
);

    arb_state_e        state_r, state_s;
    logic              grant_s;
    logic              xfer_s;
    logic [NREQ-1:0]   ready_s;
    logic              g_r;
    logic [LEN_W-1:0]  rem_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [CNT_W-1:0]  rsp_value_r;
    logic              rsp_err_r;
    logic              cnt_load_r;
    logic              cnt_mode_r;
    logic [CNT_W-1:0]  cnt_data_in_r;

    count_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (bus.req_valid),
        .advance (xfer_s),
        .grant   (grant_s)
    );

    // Next-state logic and the combinational ready/transfer decode
    always_comb begin
        state_s = state_r;
        xfer_s  = 1'b0;
        ready_s = {NREQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (!rst) begin
                    ready_s[grant_s] = 1'b1;
                end else begin
                    ready_s = {NREQ{1'b0}};
                end
                if (!rst && bus.req_valid[grant_s]) begin
                    xfer_s  = 1'b1;
                    state_s = start_ok(bus.req_start[grant_s], MOD) ? LOAD : ERR;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (rem_r != 4'd0) begin
                    state_s = RUN;
                end else begin
                    state_s = DONE;
                end
            end
            RUN: begin
                if (rem_r == 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, latched request, counter control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            g_r           <= 1'b0;
            rem_r         <= 4'd0;
            rsp_valid_r   <= {NREQ{1'b0}};
            rsp_value_r   <= 4'd0;
            rsp_err_r     <= 1'b0;
            cnt_load_r    <= 1'b0;
            cnt_mode_r    <= 1'b0;
            cnt_data_in_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            cnt_load_r  <= (state_s == LOAD);
            rsp_valid_r <= {NREQ{1'b0}};
            // Load value and direction are presented one cycle ahead, together with cnt_load
            if (xfer_s && (state_s == LOAD)) begin
                cnt_data_in_r <= bus.req_start[grant_s];
                cnt_mode_r    <= bus.req_mode[grant_s];
            end
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        g_r   <= grant_s;
                        rem_r <= bus.req_len[grant_s];
                    end
                end
                RUN: rem_r <= rem_r - 4'd1;
                DONE: begin
                    rsp_value_r   <= cnt_data_out;
                    rsp_err_r     <= 1'b0;
                    rsp_valid_r[g_r] <= 1'b1;
                end
                ERR: begin
                    rsp_value_r   <= 4'd0;
                    rsp_err_r     <= 1'b1;
                    rsp_valid_r[g_r] <= 1'b1;
                end
                default: rem_r <= rem_r;
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_value = rsp_value_r;
    assign bus.rsp_err   = rsp_err_r;
    assign cnt_rst       = rst;
    assign cnt_load      = cnt_load_r;
    assign cnt_mode      = cnt_mode_r;
    assign cnt_data_in   = cnt_data_in_r;

endmodule
